spi_byte_phy: RTL and testbench

- SPI peripheral (target) byte PHY, mode 0 (CPOL=0, CPHA=0), MSB first.
- Oversamples the external SCK/CSN/SDI pins in the system clock domain and deserialises MOSI into bytes (rx_data/rx_stb).
- Serialises queued response bytes (tx_data/tx_stb) onto MISO.
- Sits directly upstream of the SPI-to-Wishbone command state machine: feeds its byte strobe and consumes its per-byte reply.

---
 rtl/spi_byte_phy_pkg.sv | 6 +
 rtl/spi_byte_phy_if.sv | 28 ++
 rtl/spi_byte_phy_sync_edge.sv | 29 ++
 rtl/spi_byte_phy.sv | 99 +++++++++
 tb/tb_spi_byte_phy.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_byte_phy_pkg.sv
// spi_byte_phy_pkg: shared constants and state type for the SPI byte PHY
package spi_byte_phy_pkg;
   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] FILL_DEFAULT = 8'h00;
   typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/spi_byte_phy_if.sv
// spi_byte_phy_if: SPI pins plus byte-level rx/tx handshake of the PHY
//   spi_sck/spi_csn/spi_sdi : pins into the PHY (asynchronous)
//   spi_sdo/spi_sdo_oe      : MISO data and output enable
//   rx_data/rx_stb          : received byte and its one-cycle strobe
//   tx_data/tx_stb          : reply byte and its one-cycle queue strobe
//   tx_underrun/selected    : fill-byte pulse and synchronised select
interface spi_byte_phy_if;
   import spi_byte_phy_pkg::*;
   logic              spi_sck;
   logic              spi_csn;
   logic              spi_sdi;
   logic              spi_sdo;
   logic              spi_sdo_oe;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_stb;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_stb;
   logic              tx_underrun;
   logic              selected;
   modport slave (
      input  spi_sck, spi_csn, spi_sdi, tx_data, tx_stb,
      output spi_sdo, spi_sdo_oe, rx_data, rx_stb, tx_underrun, selected
   );
   modport master (
      output spi_sck, spi_csn, spi_sdi, tx_data, tx_stb,
      input  spi_sdo, spi_sdo_oe, rx_data, rx_stb, tx_underrun, selected
   );
endinterface

// File: rtl/spi_byte_phy_sync_edge.sv
// spi_sync_edge: multi-stage synchroniser with one-clk rise/fall pulses
//   clk, rst_n : system clock, async active-low reset (chain presets to RST_VAL)
//   d_i        : asynchronous input pin
//   rise_o     : one-cycle pulse on synchronised 0->1
//   fall_o     : one-cycle pulse on synchronised 1->0
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end
   assign rise_o = sync_q[STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_byte_phy.sv
// spi_byte_phy: SPI mode-0 target byte PHY (MSB first) with single-entry reply buffer
//   clk, rst_n : system clock (SCK <= clk/8), async active-low reset
//   bus        : spi_byte_phy_if.slave -- SPI pins, rx byte strobe, tx reply queue,
//                underrun pulse and synchronised select
module spi_byte_phy
   import spi_byte_phy_pkg::*;
#(
   parameter int                SYNC_STAGES = 2,
   parameter logic [BYTE_W-1:0] FILL_BYTE   = FILL_DEFAULT
) (
   input logic           clk,
   input logic           rst_n,
   spi_byte_phy_if.slave bus
);
   logic sck_rise, sck_fall, cs_start, cs_end, sdi_s;
   logic [SYNC_STAGES-1:0] sdi_q;
   state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-2:0] rx_shift_q, rx_shift_d;
   logic [BYTE_W-1:0] tx_shift_q, tx_shift_d, tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
   logic tx_buf_valid_q, tx_buf_valid_d, rx_done_q, rx_done_d, rx_stb_q, underrun_q, underrun_d;
   logic load, shift_tx, rx_en, end_x;
   logic [BYTE_W-1:0] load_byte, rx_next;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .clk(clk), .rst_n(rst_n), .d_i(bus.spi_sck), .rise_o(sck_rise), .fall_o(sck_fall)
   );
   // csn idles high; its falling edge starts a transfer, rising edge ends it
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
      .clk(clk), .rst_n(rst_n), .d_i(bus.spi_csn), .rise_o(cs_end), .fall_o(cs_start)
   );

   // sdi shares the sck synchroniser depth so it is stable when sck_rise fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sdi_q <= '0;
      else        sdi_q <= {sdi_q[SYNC_STAGES-2:0], bus.spi_sdi};
   end
   assign sdi_s = sdi_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = (state_q == IDLE) ? (cs_start ? SHIFT : IDLE) : (cs_end ? IDLE : SHIFT);
   end

   always_comb begin
      end_x          = (state_q == SHIFT) && cs_end;
      rx_en          = (state_q == SHIFT) && !cs_end && sck_rise;
      load           = ((state_q == IDLE) && cs_start) ||
                       ((state_q == SHIFT) && !cs_end && sck_fall && bit_cnt_q == 3'd0);
      shift_tx       = (state_q == SHIFT) && !cs_end && sck_fall && bit_cnt_q != 3'd0;
      load_byte      = tx_buf_valid_q ? tx_buf_q : FILL_BYTE;
      rx_next        = {rx_shift_q, sdi_s};
      bit_cnt_d      = end_x ? 3'd0 : rx_en ? bit_cnt_q + 3'd1 : bit_cnt_q;
      rx_shift_d     = rx_en ? rx_next[BYTE_W-2:0] : rx_shift_q;
      rx_done_d      = rx_en && bit_cnt_q == 3'd7;
      rx_data_d      = rx_done_d ? rx_next : rx_data_q;
      tx_shift_d     = load ? load_byte : shift_tx ? {tx_shift_q[BYTE_W-2:0], 1'b0} : tx_shift_q;
      tx_buf_d       = bus.tx_stb ? bus.tx_data : tx_buf_q;
      // a strobe coinciding with a load refills the buffer after the old byte is taken
      tx_buf_valid_d = end_x ? 1'b0 : bus.tx_stb ? 1'b1 : load ? 1'b0 : tx_buf_valid_q;
      underrun_d     = load && !tx_buf_valid_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q      <= '0;
         rx_shift_q     <= '0;
         rx_data_q      <= '0;
         rx_done_q      <= 1'b0;
         rx_stb_q       <= 1'b0;
         tx_shift_q     <= '0;
         tx_buf_q       <= '0;
         tx_buf_valid_q <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         bit_cnt_q      <= bit_cnt_d;
         rx_shift_q     <= rx_shift_d;
         rx_data_q      <= rx_data_d;
         rx_done_q      <= rx_done_d;
         rx_stb_q       <= rx_done_q;
         tx_shift_q     <= tx_shift_d;
         tx_buf_q       <= tx_buf_d;
         tx_buf_valid_q <= tx_buf_valid_d;
         underrun_q     <= underrun_d;
      end
   end

   // MISO is the shifter MSB, gated to zero whenever not selected
   assign bus.selected    = (state_q == SHIFT);
   assign bus.spi_sdo_oe  = (state_q == SHIFT);
   assign bus.spi_sdo     = (state_q == SHIFT) & tx_shift_q[BYTE_W-1];
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_stb      = rx_stb_q;
   assign bus.tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_byte_phy.sv
// tb_spi_byte_phy: table-driven and scoreboard checks of the SPI byte PHY
module tb_spi_byte_phy;
   typedef struct {
      logic [7:0] mosi;
      int         nstb;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] miso;
      int         und;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_byte_phy_if ifc();
   spi_byte_phy #(.SYNC_STAGES(2), .FILL_BYTE(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
   );

   int checks = 0;
   int errors = 0;
   int half = 6;
   logic [7:0] exp_q[$];
   logic [7:0] imm_mem[16];
   int imm_wr = 0, imm_rd = 0;
   logic [7:0] rep_mem[16];
   int rep_wr = 0, rep_rd = 0;
   logic echo_en = 1'b0;
   logic [7:0] got_data[64];
   int got_und[64];
   int got_wr = 0, got_rd = 0;
   int und_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (ifc.rx_stb) begin
            got_data[got_wr % 64] = ifc.rx_data;
            got_und[got_wr % 64]  = und_cnt;
            got_wr++;
         end
         if (ifc.tx_underrun) und_cnt++;
      end
   end

   initial begin
      ifc.tx_stb  = 1'b0;
      ifc.tx_data = 8'h00;
      forever begin
         @(negedge clk);
         if (ifc.rx_stb && echo_en) begin
            ifc.tx_data = ifc.rx_data;
            ifc.tx_stb  = 1'b1;
         end else if (ifc.rx_stb && rep_rd != rep_wr) begin
            ifc.tx_data = rep_mem[rep_rd % 16];
            rep_rd++;
            ifc.tx_stb  = 1'b1;
         end else if (!ifc.tx_stb && imm_rd != imm_wr) begin
            ifc.tx_data = imm_mem[imm_rd % 16];
            imm_rd++;
            ifc.tx_stb  = 1'b1;
         end else ifc.tx_stb = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic push_imm(input logic [7:0] d);
      imm_mem[imm_wr % 16] = d;
      imm_wr++;
   endtask

   task automatic sel();
      ifc.spi_csn = 1'b0;
      tick(half);
   endtask

   task automatic desel();
      tick(half);
      ifc.spi_csn = 1'b1;
      tick(8);
   endtask

   task automatic xfer(input string nm, input logic [7:0] mosi, input logic [7:0] miso);
      logic [7:0] got;
      got = 8'h00;
      exp_q.push_back(mosi);
      for (int i = 7; i >= 0; i--) begin
         ifc.spi_sdi = mosi[i];
         tick(half);
         got[i] = ifc.spi_sdo;
         ifc.spi_sck = 1'b1;
         tick(half);
         ifc.spi_sck = 1'b0;
      end
      chk({nm, "_miso"}, {24'h0, got}, {24'h0, miso});
   endtask

   task automatic drain(input string nm);
      logic [7:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_rd == got_wr) begin
            checks++;
            errors++;
            $display("FAIL %s_rx missing rx_stb expected %0h", nm, e);
         end else begin
            chk({nm, "_rx"}, {24'h0, got_data[got_rd % 64]}, {24'h0, e});
            got_rd++;
         end
      end
      chk({nm, "_rx_extra"}, got_wr - got_rd, 0);
      got_rd = got_wr;
   endtask

   initial begin
      vec_t vecs[5];
      int base, idx;
      vecs[0] = '{mosi: 8'hA5, nstb: 0, a: 8'h00, b: 8'h00, miso: 8'h00, und: 1};
      vecs[1] = '{mosi: 8'h3C, nstb: 1, a: 8'h5A, b: 8'h00, miso: 8'h5A, und: 0};
      vecs[2] = '{mosi: 8'h96, nstb: 2, a: 8'h11, b: 8'h22, miso: 8'h22, und: 0};
      vecs[3] = '{mosi: 8'h00, nstb: 1, a: 8'hFF, b: 8'h00, miso: 8'hFF, und: 0};
      vecs[4] = '{mosi: 8'hFF, nstb: 2, a: 8'h80, b: 8'h01, miso: 8'h01, und: 0};
      ifc.spi_sck = 1'b0;
      ifc.spi_csn = 1'b1;
      ifc.spi_sdi = 1'b0;
      tick(2);
      chk("rst_sdo", ifc.spi_sdo, 0);
      chk("rst_oe", ifc.spi_sdo_oe, 0);
      chk("rst_rx_data", ifc.rx_data, 0);
      chk("rst_rx_stb", ifc.rx_stb, 0);
      chk("rst_underrun", ifc.tx_underrun, 0);
      chk("rst_selected", ifc.selected, 0);
      rst_n = 1'b1;
      tick(4);

      for (int v = 0; v < 5; v++) begin
         base = und_cnt;
         if (vecs[v].nstb > 0) push_imm(vecs[v].a);
         if (vecs[v].nstb > 1) push_imm(vecs[v].b);
         tick(8);
         sel();
         chk("vec_selected", ifc.selected, 1);
         xfer("vec", vecs[v].mosi, vecs[v].miso);
         desel();
         idx = got_rd;
         drain("vec");
         chk("vec_und", got_und[idx % 64] - base, vecs[v].und);
      end

      base = und_cnt;
      rep_mem[rep_wr % 16] = 8'h3C;
      rep_wr++;
      sel();
      xfer("two_b0", 8'h81, 8'h00);
      xfer("two_b1", 8'h42, 8'h3C);
      desel();
      drain("two");
      chk("two_und", und_cnt - base, 2);

      sel();
      for (int i = 0; i < 5; i++) begin
         ifc.spi_sdi = 1'b1;
         tick(half);
         ifc.spi_sck = 1'b1;
         tick(half);
         ifc.spi_sck = 1'b0;
      end
      tick(half);
      chk("abort_oe_before", ifc.spi_sdo_oe, 1);
      ifc.spi_csn = 1'b1;
      tick(3);
      chk("abort_oe", ifc.spi_sdo_oe, 0);
      chk("abort_selected", ifc.selected, 0);
      tick(8);
      chk("abort_no_rx", got_wr - got_rd, 0);
      sel();
      xfer("after_abort", 8'h0F, 8'h00);
      desel();
      drain("after_abort");

      sel();
      push_imm(8'h77);
      for (int i = 0; i < 3; i++) begin
         ifc.spi_sdi = i[0];
         tick(half);
         ifc.spi_sck = 1'b1;
         tick(half);
         ifc.spi_sck = 1'b0;
      end
      tick(2);
      rst_n = 1'b0;
      ifc.spi_csn = 1'b1;
      ifc.spi_sck = 1'b0;
      #1;
      chk("mid_rst_sdo", ifc.spi_sdo, 0);
      chk("mid_rst_oe", ifc.spi_sdo_oe, 0);
      chk("mid_rst_rx_data", ifc.rx_data, 0);
      chk("mid_rst_selected", ifc.selected, 0);
      chk("mid_rst_underrun", ifc.tx_underrun, 0);
      tick(2);
      rst_n = 1'b1;
      tick(4);
      got_rd = got_wr;
      sel();
      xfer("after_rst", 8'hC3, 8'h00);
      desel();
      drain("after_rst");

      half = 4;
      echo_en = 1'b1;
      base = und_cnt;
      sel();
      xfer("b2b0", 8'h5A, 8'h00);
      xfer("b2b1", 8'hC7, 8'h5A);
      xfer("b2b2", 8'h01, 8'hC7);
      xfer("b2b3", 8'hFE, 8'h01);
      desel();
      echo_en = 1'b0;
      drain("b2b");
      chk("b2b_und", und_cnt - base, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
